// File: rtl/upcnt_timer_pkg.sv
// Shared constants for the loadable up-counter timer: default width and
// the compare-register reset pattern.
package upcnt_timer_pkg;

  localparam int          UPCNT_WIDTH_DEF = 16;
  localparam logic [31:0] CMP_RST_ALL     = 32'hFFFF_FFFF;

endpackage

// File: rtl/upcnt_timer_upcnts.sv
// One up-count bit slice: toggles when its carry-in is set, with parallel
// load and synchronous clear; carry-out ripples to the next slice.
module upcnts (
  output logic q,
  output logic co,
  input  logic d,
  input  logic ci,
  input  logic ld,
  input  logic clr,
  input  logic sys_clk,
  input  logic reset
);

  logic q_q;
  logic q_d;

  // next bit: load or toggle, then forced low by clear
  always_comb begin
    q_d = 1'b0;
    if (ld) begin
      q_d = d & ~clr;
    end else begin
      q_d = (q_q ^ ci) & ~clr;
    end
  end

  // bit state register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = ci & q_q;

endmodule

// File: rtl/upcnt_timer.sv
// Loadable up-counter timer: ripple chain of bit slices plus compare
// register, one-cycle match pulse and sticky overflow flag.
module upcnt_timer
  import upcnt_timer_pkg::*;
#(
  parameter int WIDTH = UPCNT_WIDTH_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             ci,
  input  logic             clr,
  input  logic             cmp_we,
  input  logic [WIDTH-1:0] cmp_d,
  input  logic             ovf_ack,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             match,
  output logic             ovf
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] cmp_q;
  logic [WIDTH-1:0] cmp_nxt_d;
  logic             match_q;
  logic             match_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             wrap_s;
  logic             update_s;

  assign carry_s[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    upcnts u_slice (
      .q       (q_s[i]),
      .co      (carry_s[i+1]),
      .d       (d[i]),
      .ci      (carry_s[i]),
      .ld      (ld),
      .clr     (clr),
      .sys_clk (sys_clk),
      .reset   (reset)
    );
  end

  // mirror of the slice next-state so match lines up with the new q
  always_comb begin
    q_next_s = {WIDTH{1'b0}};
    if (clr) begin
      q_next_s = {WIDTH{1'b0}};
    end else if (ld) begin
      q_next_s = d;
    end else begin
      q_next_s = q_s ^ carry_s[WIDTH-1:0];
    end
  end

  assign update_s = clr | ld | ci;
  assign wrap_s   = carry_s[WIDTH] & ~ld & ~clr;

  // compare, match and sticky overflow next-state; wrap beats ack
  always_comb begin
    cmp_nxt_d = cmp_q;
    match_d   = update_s & (q_next_s == cmp_q);
    ovf_d     = ovf_q;
    if (cmp_we) begin
      cmp_nxt_d = cmp_d;
    end else begin
      cmp_nxt_d = cmp_q;
    end
    if (wrap_s) begin
      ovf_d = 1'b1;
    end else if (ovf_ack) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // status and compare registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cmp_q   <= CMP_RST_ALL[WIDTH-1:0];
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cmp_q   <= cmp_nxt_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q     = q_s;
  assign co    = carry_s[WIDTH];
  assign match = match_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_upcnt_timer.sv
// Directed self-checking bench for upcnt_timer at WIDTH = 16.
module tb_upcnt_timer;

  logic        sys_clk;
  logic        reset;
  logic        ld;
  logic [15:0] d;
  logic        ci;
  logic        clr;
  logic        cmp_we;
  logic [15:0] cmp_d;
  logic        ovf_ack;
  logic [15:0] q;
  logic        co;
  logic        match;
  logic        ovf;

  int tests;
  int fails;

  upcnt_timer #(.WIDTH(16)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .ld      (ld),
    .d       (d),
    .ci      (ci),
    .clr     (clr),
    .cmp_we  (cmp_we),
    .cmp_d   (cmp_d),
    .ovf_ack (ovf_ack),
    .q       (q),
    .co      (co),
    .match   (match),
    .ovf     (ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    ld = 1'b0; ci = 1'b0; clr = 1'b0; cmp_we = 1'b0; ovf_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); d = 16'h0000; cmp_d = 16'h0000;
    tick(); tick();
    tests++; if (q !== 16'h0000) begin fails++; $display("FAIL reset_q got=%h exp=0000", q); end
    tests++; if ({co, match, ovf} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {co, match, ovf}); end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_count();
    ci = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests++; if (q !== 16'(i)) begin fails++; $display("FAIL count_q got=%h exp=%h", q, 16'(i)); end
    end
    ci = 1'b0;
    tests++; if ({match, ovf} !== 2'b00) begin fails++; $display("FAIL count_flags got=%b exp=00", {match, ovf}); end
  endtask

  task automatic test_match();
    logic [4:0] exp_m;
    exp_m = 5'b01000; // match only when q = 3
    cmp_we = 1'b1; cmp_d = 16'h0003; tick(); cmp_we = 1'b0;
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL match_cmpwrite got=%b exp=0", match); end
    clr = 1'b1; tick(); clr = 1'b0;
    tests++; if (q !== 16'h0000) begin fails++; $display("FAIL match_clr got=%h exp=0000", q); end
    ci = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (match !== exp_m[i]) begin fails++; $display("FAIL match_q%0d got=%b exp=%b", i, match, exp_m[i]); end
    end
    ci = 1'b0;
  endtask

  task automatic test_wrap();
    ld = 1'b1; d = 16'hFFFE; tick(); ld = 1'b0;
    ci = 1'b1; #1;
    tests++; if (co !== 1'b0) begin fails++; $display("FAIL wrap_co_fffe got=%b exp=0", co); end
    tick();
    tests++; if (q !== 16'hFFFF || co !== 1'b1) begin fails++; $display("FAIL wrap_ffff got q=%h co=%b exp q=ffff co=1", q, co); end
    ovf_ack = 1'b1; tick();
    tests++; if (q !== 16'h0000 || ovf !== 1'b1) begin fails++; $display("FAIL wrap_set_wins got q=%h ovf=%b exp q=0000 ovf=1", q, ovf); end
    ovf_ack = 1'b0; ci = 1'b0; tick();
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL wrap_sticky got=%b exp=1", ovf); end
    ovf_ack = 1'b1; tick(); ovf_ack = 1'b0;
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL wrap_ack got=%b exp=0", ovf); end
  endtask

  task automatic test_priority();
    ld = 1'b1; d = 16'h0055; tick();
    clr = 1'b1; ci = 1'b1; d = 16'h1234; tick(); clr = 1'b0;
    tests++; if (q !== 16'h0000) begin fails++; $display("FAIL prio_clr got=%h exp=0000", q); end
    tick();
    tests++; if (q !== 16'h1234 || ovf !== 1'b0) begin fails++; $display("FAIL prio_ld got q=%h ovf=%b exp q=1234 ovf=0", q, ovf); end
    ci = 1'b0; d = 16'hFFFF; tick();
    ci = 1'b1; d = 16'h0010; #1;
    tests++; if (co !== 1'b1) begin fails++; $display("FAIL prio_co_ld got=%b exp=1", co); end
    tick(); idle();
    tests++; if (q !== 16'h0010 || ovf !== 1'b0) begin fails++; $display("FAIL prio_ld_nowrap got q=%h ovf=%b exp q=0010 ovf=0", q, ovf); end
  endtask

  task automatic test_back_to_back();
    ld = 1'b1; d = 16'h0007; tick(); ld = 1'b0;
    cmp_we = 1'b1; cmp_d = 16'h0007; tick(); cmp_we = 1'b0;
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL rearm_cmpwrite got=%b exp=0", match); end
    tick();
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL rearm_static got=%b exp=0", match); end
    ld = 1'b1; tick();
    tests++; if (match !== 1'b1) begin fails++; $display("FAIL rearm_ld1 got=%b exp=1", match); end
    tick();
    tests++; if (match !== 1'b1) begin fails++; $display("FAIL rearm_ld2 got=%b exp=1", match); end
    ld = 1'b0; tick();
    tests++; if (match !== 1'b0 || q !== 16'h0007) begin fails++; $display("FAIL rearm_drop got m=%b q=%h exp m=0 q=0007", match, q); end
  endtask

  task automatic test_async_reset();
    ld = 1'b1; d = 16'hFFFF; tick(); ld = 1'b0;
    ci = 1'b1; tick(); ci = 1'b0;
    cmp_we = 1'b1; cmp_d = 16'h00AA; ld = 1'b1; d = 16'h00A9; tick(); cmp_we = 1'b0; ld = 1'b0;
    ci = 1'b1; tick();
    tests++; if (q !== 16'h00AA || match !== 1'b1 || ovf !== 1'b1) begin fails++; $display("FAIL areset_pre got q=%h m=%b o=%b exp q=00aa m=1 o=1", q, match, ovf); end
    #2 reset = 1'b1;
    #1;
    tests++; if (q !== 16'h0000 || match !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL areset_now got q=%h m=%b o=%b exp q=0000 m=0 o=0", q, match, ovf); end
    tick();
    tests++; if (q !== 16'h0000) begin fails++; $display("FAIL areset_hold got=%h exp=0000", q); end
    #2 reset = 1'b0;
    tick();
    tests++; if (q !== 16'h0001 || match !== 1'b0) begin fails++; $display("FAIL areset_resume got q=%h m=%b exp q=0001 m=0", q, match); end
    ci = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_count();
    test_match();
    test_wrap();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
